// File: rtl/mem_port_pkg.sv
// Shared types for the memory-arbiter requester port.
// Descriptor layout, error codes and FSM states.
package mem_port_pkg;

  localparam int ADDR_W     = 48;
  localparam int LEN_W      = 32;
  localparam int DESC_TAG_W = 4;

  typedef enum logic [1:0] {
    ERR_OK,
    ERR_BAD_LEN,
    ERR_MISALIGN,
    ERR_TIMEOUT
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CPL
  } state_e;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_W-1:0]     addr;
    logic [LEN_W-1:0]      len;
    logic [DESC_TAG_W-1:0] tag;
  } desc_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// In-order descriptor FIFO with registered push_ready.
// A full FIFO refuses a push even when a pop happens the same cycle.
module mem_cmd_fifo
  import mem_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_valid,
  output logic  push_ready,
  input  desc_t push_data,
  input  logic  pop,
  output logic  empty,
  output desc_t head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  desc_t         mem_q [DEPTH];

  logic push;
  logic pop_ok;

  assign push   = push_valid && rdy_q;
  assign pop_ok = pop && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop_ok);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop_ok);
    rdy_d = (cnt_d != (PW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  assign push_ready = rdy_q;
  assign empty      = (cnt_q == '0);
  assign head       = mem_q[rd_q];

endmodule

// File: rtl/mem_port_initiator.sv
// Requester engine: FIFO, validation, hold-until-ack request, tagged completion.
// Define MEM_PORT_TIMEOUT_EN to build the REQ-phase ack watchdog.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int N           = 4096,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = mem_port_pkg::DESC_TAG_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              req,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W-1:0]  len,
  input  logic              ack,
  output logic              cpl_valid,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic              cpl_rw,
  output logic [1:0]        cpl_err,
  output logic              busy,
  output logic              spurious_ack
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2)
  begin : g_bad_cfg
    $error("mem_port_initiator: bad DEPTH or TIMEOUT_CYC");
  end

  state_e state_q, state_d;
  desc_t  hold_q, hold_d;
  err_e   err_q, err_d;
  logic   spur_q, spur_d;
  logic   pop;
  logic   empty;
  desc_t  head;
  desc_t  push_data;

  assign push_data = '{
    rw:   cmd_rw,
    addr: cmd_addr,
    len:  cmd_len,
    tag:  DESC_TAG_W'(cmd_tag)
  };

  mem_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_valid(cmd_valid),
    .push_ready(cmd_ready),
    .push_data (push_data),
    .pop       (pop),
    .empty     (empty),
    .head      (head)
  );

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam int CNT_W = (CW > 11) ? CW : 11;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pop     = 1'b0;
    spur_d  = spur_q | (ack && state_q != S_REQ);
`ifdef MEM_PORT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          hold_d = head;
`ifdef MEM_PORT_TIMEOUT_EN
          cnt_d  = '0;
`endif
          // Length errors take precedence over alignment errors
          if (head.len == '0 || head.len > LEN_W'(N)) begin
            err_d   = ERR_BAD_LEN;
            state_d = S_CPL;
          end else if (head.addr[2:0] != 3'd0) begin
            err_d   = ERR_MISALIGN;
            state_d = S_CPL;
          end else begin
            err_d   = ERR_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (ack) begin
          err_d   = ERR_OK;
          state_d = S_CPL;
`ifdef MEM_PORT_TIMEOUT_EN
        end else if (expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_CPL;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_CPL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      err_q   <= ERR_OK;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      spur_q  <= spur_d;
    end
  end

  assign req          = (state_q == S_REQ);
  assign rw           = req ? hold_q.rw : 1'b0;
  assign addr         = req ? hold_q.addr : '0;
  assign len          = req ? hold_q.len : '0;
  assign cpl_valid    = (state_q == S_CPL);
  assign cpl_tag      = cpl_valid ? TAG_W'(hold_q.tag) : '0;
  assign cpl_rw       = cpl_valid ? hold_q.rw : 1'b0;
  assign cpl_err      = cpl_valid ? err_q : ERR_OK;
  assign busy         = !empty || (state_q != S_IDLE);
  assign spurious_ack = spur_q;

endmodule
